// File: rtl/trace_capture_fifo_if.sv
// Trace capture handshake bundle: core-side beat strobe plus the valid/ready drain port.
// slave = the FIFO, master = the beat source / drain consumer.
interface trace_capture_fifo_if #(
  parameter int DATA_W = 36,
  parameter int OUT_W  = 36
);
  logic              trace_valid;
  logic [DATA_W-1:0] trace_data;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;

  modport master (
    output trace_valid, trace_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  trace_valid, trace_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/trace_capture_fifo.sv
// Non-stalling trace capture FIFO: first-word-fall-through drain, sticky overflow and
// saturating drop counter. Define TRACE_TIMESTAMP_EN to prepend a cycle timestamp to each entry.
module trace_capture_fifo #(
  parameter int DATA_W     = 36,
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  trace_capture_fifo_if.slave   bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_USED = 1;
`else
  localparam int TS_USED = 0;
`endif
  localparam int OUT_W = DATA_W + TS_USED * TS_W;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [OUT_W-1:0]      mem [DEPTH];
  logic [OUT_W-1:0]      entry;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  assign bus.out_valid = (level != '0);
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.trace_valid && (!full || pop);
  assign drop = bus.trace_valid && full && !pop;

  // Gate the head so out_data reads zero whenever the FIFO is empty or in reset.
  assign bus.out_data = bus.out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ts <= '0;
    else         ts <= ts + 1'b1;
  end

  assign entry = {ts, bus.trace_data};
`else
  assign entry = bus.trace_data;
`endif

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[DEPTH_LOG2-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Directed + randomized bench for trace_capture_fifo against a queue-based reference model.
module tb_trace_capture_fifo;
  localparam int DATA_W = 36;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int OUT_W = DATA_W + TS_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic        clk;
  logic        resetn;
  logic        clear;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  trace_capture_fifo_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  trace_capture_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(4), .TS_W(TS_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .bus        (bus),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] q [$];
  logic              m_ovf;
  int                m_dc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_dc));
    if (q.size() != 0) chk("out_data", 64'(bus.out_data[DATA_W-1:0]), 64'(q[0]));
  endtask

  // One clock: drive inputs, advance the reference model at the edge, then compare.
  task automatic cycle(input bit tv, input logic [DATA_W-1:0] td, input bit rdy, input bit clr);
    bit pop;
    bus.trace_valid = tv;
    bus.trace_data  = td;
    bus.out_ready   = rdy;
    clear           = clr;
    @(posedge clk);
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      pop = (q.size() != 0) && rdy;
      if (tv && q.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
        if (m_dc != 65535) m_dc++;
      end else begin
        if (pop) void'(q.pop_front());
        if (tv) q.push_back(td);
      end
    end
    #1;
    check_all();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_budget", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int pushed;
    int guard;
    bit tv;
    bit rdy;
    logic [DATA_W-1:0] d;

    resetn          = 1'b0;
    clear           = 1'b0;
    bus.trace_valid = 1'b0;
    bus.trace_data  = '0;
    bus.out_ready   = 1'b0;
    m_ovf           = 1'b0;
    m_dc            = 0;
    #12;
    check_all();
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    #10 resetn = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
    // Timestamp counts edges since reset release, starting at 0 on the first edge.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 36'hA, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 36'hD, 1'b0, 1'b0);
    chk("ts_first", 64'(bus.out_data[OUT_W-1:DATA_W]), 64'd10);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("ts_second", 64'(bus.out_data[OUT_W-1:DATA_W]), 64'd13);
    drain(4);
`endif

    // Single beat held for five cycles, then popped.
    cycle(1'b1, 36'h1_2345_6789, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("single_empty", 64'(bus.out_valid), 64'd0);

    // Empty FIFO with push and ready together: push only.
    cycle(1'b1, 36'h77, 1'b1, 1'b0);
    drain(4);

    // Fill and overflow with 20 beats.
    for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_drops", 64'(drop_count), 64'd4);

    // Full with simultaneous push and pop: no drops, level held.
    for (int i = 0; i < 10; i++) cycle(1'b1, DATA_W'(100 + i), 1'b1, 1'b0);
    chk("full_pp_level", 64'(level), 64'd16);
    chk("full_pp_drops", 64'(drop_count), 64'd4);
    drain(40);

    // Random push/pop with occupancy kept at 0..3 across many pointer wraps.
    pushed = 0;
    guard  = 0;
    while (pushed < 100 && guard < 2000) begin
      tv  = ($urandom_range(2) != 0) && (q.size() < 3);
      rdy = $urandom_range(1) != 0;
      d   = {4'($urandom()), 32'($urandom())};
      cycle(tv, d, rdy, 1'b0);
      if (tv) pushed++;
      guard++;
    end
    chk("wrap_budget", 64'(pushed), 64'd100);
    drain(10);

    // Clear beats a coincident push; overflow is still set from the fill.
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(200 + i), 1'b0, 1'b0);
    chk("pre_clear_ovf", 64'(overflow), 64'd1);
    cycle(1'b1, 36'hF_FFFF_FFFF, 1'b1, 1'b1);
    chk("clear_level", 64'(level), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream empties the FIFO immediately.
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(300 + i), 1'b0, 1'b0);
    bus.trace_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
    check_all();
    chk("async_rst_out_data", 64'(bus.out_data), 64'd0);
    #2 resetn = 1'b1;
    cycle(1'b1, 36'h5_5555_5555, 1'b0, 1'b0);
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
